// File: rtl/nf10_axis_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nf10_axis_pkg
//  Description : Shared widths, FSM state encodings and the packed-slice
//                offset helper used by the NF10 AXI4-Stream arbiters.
//  Revision    : 1.0 - initial release
// ============================================================================
package nf10_axis_pkg;

    localparam int C_DEF_DATA_WIDTH  = 256;
    localparam int C_DEF_TUSER_WIDTH = 128;
    localparam int C_DEF_TSTRB_WIDTH = 32;

    // Packet arbiter FSM encodings
    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_SEND = 1'b1;

    // Bit offset of element idx inside a vector of equally sized packed slices
    function automatic int slice_offset(input int idx, input int width);
        return idx * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nf10_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : nf10_rr_pick
//  Description : Combinational rotating-priority encoder. Searches the
//                request vector starting one above last_grant and wrapping
//                modulo NUM_REQ; reports the first set request.
//  Revision    : 1.0 - initial release
// ============================================================================
module nf10_rr_pick
    import nf10_axis_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [SEL_WIDTH-1:0] last_grant,
    output logic                 found,
    output logic [SEL_WIDTH-1:0] index
);

    // Walk candidates from farthest to nearest so the nearest request wins
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (req[j] && (j == ((int'(last_grant) + k) % NUM_REQ))) begin
                    found = 1'b1;
                    index = SEL_WIDTH'(j);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/nf10_axis_pkt_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : nf10_axis_pkt_rr_arbiter
//  Description : Packet-level round-robin arbiter sharing one AXI4-Stream
//                egress between NUM_QUEUES input streams. A grant is held
//                from the first beat until the tlast handshake; the data
//                path is a pure combinational mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module nf10_axis_pkt_rr_arbiter
    import nf10_axis_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = C_DEF_DATA_WIDTH,
    parameter int C_AXIS_TUSER_WIDTH = C_DEF_TUSER_WIDTH,
    parameter int NUM_QUEUES         = 4,
    parameter int SEL_WIDTH          = 2
) (
    input  logic                                        aclk,
    input  logic                                        aresetn,
    input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
    input  logic [NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic [NUM_QUEUES-1:0]                       s_axis_tvalid,
    input  logic [NUM_QUEUES-1:0]                       s_axis_tlast,
    output logic [NUM_QUEUES-1:0]                       s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]              m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
    output logic                                        m_axis_tvalid,
    output logic                                        m_axis_tlast,
    input  logic                                        m_axis_tready,
    output logic [SEL_WIDTH-1:0]                        grant,
    output logic [7:0]                                  pkt_count,
    output logic                                        activity
);

    localparam int C_STRB_WIDTH = C_AXIS_DATA_WIDTH / 8;

    logic [0:0]           r_state;
    logic [0:0]           w_next_state;
    logic [SEL_WIDTH-1:0] r_grant;
    logic [SEL_WIDTH-1:0] r_last_grant;
    logic [7:0]           r_pkt_count;
    logic                 r_activity;
    logic                 w_pick_found;
    logic [SEL_WIDTH-1:0] w_pick_index;
    logic                 w_sel_valid;
    logic                 w_in_send;
    logic                 w_pkt_done;

    nf10_rr_pick #(
        .NUM_REQ   (NUM_QUEUES),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_pick (
        .req        (s_axis_tvalid),
        .last_grant (r_last_grant),
        .found      (w_pick_found),
        .index      (w_pick_index)
    );

    // Zero-latency mux of the granted slice onto the egress port
    always_comb begin
        m_axis_tdata = '0;
        m_axis_tstrb = '0;
        m_axis_tuser = '0;
        m_axis_tlast = 1'b0;
        w_sel_valid  = 1'b0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (r_grant == SEL_WIDTH'(i)) begin
                m_axis_tdata = s_axis_tdata[slice_offset(i, C_AXIS_DATA_WIDTH) +: C_AXIS_DATA_WIDTH];
                m_axis_tstrb = s_axis_tstrb[slice_offset(i, C_STRB_WIDTH) +: C_STRB_WIDTH];
                m_axis_tuser = s_axis_tuser[slice_offset(i, C_AXIS_TUSER_WIDTH) +: C_AXIS_TUSER_WIDTH];
                m_axis_tlast = s_axis_tlast[i];
                w_sel_valid  = s_axis_tvalid[i];
            end
        end
    end

    // FSM state register; reset abandons any packet in flight
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: arbitrate in IDLE, hold the grant until the tlast handshake
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_ST_IDLE: if (w_pick_found) w_next_state = C_ST_SEND;
            C_ST_SEND: if (w_pkt_done)   w_next_state = C_ST_IDLE;
            default:   w_next_state = C_ST_IDLE;
        endcase
    end

    // FSM outputs: egress valid and the single routed ready exist only in SEND
    always_comb begin
        w_in_send     = (r_state == C_ST_SEND);
        m_axis_tvalid = w_in_send & w_sel_valid;
        w_pkt_done    = m_axis_tvalid & m_axis_tready & m_axis_tlast;
        s_axis_tready = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            s_axis_tready[i] = w_in_send & m_axis_tready & (r_grant == SEL_WIDTH'(i));
        end
    end

    // Grant capture, round-robin pointer, packet counter and activity pulse
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_grant      <= '0;
            r_last_grant <= SEL_WIDTH'(NUM_QUEUES - 1);
            r_pkt_count  <= '0;
            r_activity   <= 1'b0;
        end else begin
            r_activity <= w_pkt_done;
            if ((r_state == C_ST_IDLE) && w_pick_found) begin
                r_grant <= w_pick_index;
            end
            if (w_pkt_done) begin
                r_last_grant <= r_grant;
                r_pkt_count  <= r_pkt_count + 8'd1;
            end
        end
    end

    assign grant     = r_grant;
    assign pkt_count = r_pkt_count;
    assign activity  = r_activity;

endmodule
`default_nettype wire

// File: tb/tb_nf10_axis_pkt_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nf10_axis_pkt_rr_arbiter
//  Description : Randomised scoreboard bench for the packet round-robin
//                arbiter, with a packet-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nf10_axis_pkt_rr_arbiter;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int SW = DW / 8;
    localparam int NQ = 4;
    localparam int GW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              aresetn = 1'b0;
    logic [NQ*DW-1:0]  s_tdata = '0;
    logic [NQ*SW-1:0]  s_tstrb = '0;
    logic [NQ*UW-1:0]  s_tuser = '0;
    logic [NQ-1:0]     s_tvalid = '0;
    logic [NQ-1:0]     s_tlast = '0;
    logic [NQ-1:0]     s_ready;
    logic [DW-1:0]     m_tdata;
    logic [SW-1:0]     m_tstrb;
    logic [UW-1:0]     m_tuser;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready = 1'b0;
    logic [GW-1:0]     grant;
    logic [7:0]        pkt_count;
    logic              activity;

    nf10_axis_pkt_rr_arbiter #(
        .C_AXIS_DATA_WIDTH  (DW),
        .C_AXIS_TUSER_WIDTH (UW),
        .NUM_QUEUES         (NQ),
        .SEL_WIDTH          (GW)
    ) dut (
        .aclk          (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_ready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .grant         (grant),
        .pkt_count     (pkt_count),
        .activity      (activity)
    );

    always #5 clk = ~clk;

    // Stimulus knobs (written by the main sequence only)
    int vprob [NQ];
    int rprob = 100;
    int len_min = 1;
    int len_max = 1;
    int gen_total [NQ];

    // Source state (owned by the driver)
    beat_t       src_q [NQ][$];
    int          gen_made [NQ];
    logic [NQ-1:0] acc = '0;

    // Reference model and scoreboard
    beat_t       exp_q [$];
    bit          m_busy = 1'b0;
    int          m_grant = 0;
    int          m_last = NQ - 1;
    int          m_left = 0;
    logic [7:0]  m_cnt = 8'd0;
    bit          m_pulse = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int act_seen = 0;
    int act_base = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic gen_pkt(input int q);
        int    len;
        beat_t b;
        len = int'($urandom_range(len_max, len_min));
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            b.strb = $urandom;
            b.user = {$urandom, $urandom, $urandom, $urandom};
            b.last = (i == len - 1);
            src_q[q].push_back(b);
        end
    endtask

    // Sources: retire accepted beats, create packets on demand, present head beats
    always @(negedge clk) begin
        #1;
        if (!aresetn) begin
            for (int q = 0; q < NQ; q++) begin
                src_q[q].delete();
                gen_made[q] = gen_total[q];
            end
            s_tvalid = '0;
            acc = '0;
        end else begin
            for (int q = 0; q < NQ; q++) begin
                if (acc[q] && src_q[q].size() > 0) void'(src_q[q].pop_front());
                if (src_q[q].size() == 0 && gen_made[q] < gen_total[q]) begin
                    gen_pkt(q);
                    gen_made[q]++;
                end
                if (!(s_tvalid[q] && !acc[q]))
                    s_tvalid[q] = (src_q[q].size() > 0) && ($urandom_range(99) < vprob[q]);
                if (src_q[q].size() > 0) begin
                    s_tdata[q*DW +: DW] = src_q[q][0].data;
                    s_tstrb[q*SW +: SW] = src_q[q][0].strb;
                    s_tuser[q*UW +: UW] = src_q[q][0].user;
                    s_tlast[q]          = src_q[q][0].last;
                end
            end
            m_tready = ($urandom_range(99) < rprob);
            #1;
            acc = s_tvalid & s_ready;
        end
    end

    // Reference model: packet-granular round robin with one idle cycle between packets
    always @(posedge clk or negedge aresetn) begin
        int  q;
        bit  found;
        if (!aresetn) begin
            m_busy  = 1'b0;
            m_last  = NQ - 1;
            m_cnt   = 8'd0;
            m_pulse = 1'b0;
            m_grant = 0;
            exp_q.delete();
        end else begin
            m_pulse = 1'b0;
            if (m_busy) begin
                if (s_tvalid[m_grant] && m_tready) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy  = 1'b0;
                        m_last  = m_grant;
                        m_cnt   = m_cnt + 8'd1;
                        m_pulse = 1'b1;
                    end
                end
            end else begin
                found = 1'b0;
                for (int k = 1; k <= NQ; k++) begin
                    q = (m_last + k) % NQ;
                    if (!found && s_tvalid[q]) begin
                        found   = 1'b1;
                        m_busy  = 1'b1;
                        m_grant = q;
                        m_left  = 0;
                        for (int i = 0; i < src_q[q].size(); i++) begin
                            exp_q.push_back(src_q[q][i]);
                            m_left++;
                            if (src_q[q][i].last) break;
                        end
                    end
                end
            end
        end
    end

    // Monitor: compare every cycle's egress view against the model
    always @(negedge clk) begin
        logic [NQ-1:0] er;
        beat_t         b;
        #2;
        er = '0;
        if (m_busy && m_tready) er[m_grant] = 1'b1;
        chk("m_axis_tvalid", m_tvalid, m_busy && s_tvalid[m_grant]);
        chk("s_axis_tready", s_ready, er);
        chk("pkt_count", pkt_count, m_cnt);
        chk("activity", activity, m_pulse);
        if (activity) act_seen++;
        if (m_busy) chk("grant", grant, m_grant);
        if (m_tvalid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: actual=valid beat required=no beat (t=%0t)", $time);
            end else begin
                b = exp_q[0];
                chk("m_axis_tdata", m_tdata, b.data);
                chk("m_axis_tstrb", m_tstrb, b.strb);
                chk("m_axis_tuser", m_tuser, b.user);
                chk("m_axis_tlast", m_tlast, b.last);
                if (m_tready) void'(exp_q.pop_front());
            end
        end
    end

    function automatic bit all_idle();
        for (int q = 0; q < NQ; q++)
            if (src_q[q].size() != 0 || gen_made[q] != gen_total[q]) return 1'b0;
        return !m_busy && exp_q.size() == 0;
    endfunction

    task automatic drain(input int budget, input string what);
        int c = 0;
        while (!all_idle() && c < budget) begin
            @(negedge clk);
            c++;
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (c >= budget) begin
            n_fail++;
            $display("FAIL %s_drain: actual=busy after %0d cycles required=idle", what, budget);
        end
    endtask

    task automatic wait_busy(input int budget, input string what);
        int c = 0;
        while (!m_busy && c < budget) begin
            @(negedge clk);
            #2;
            c++;
        end
        n_checks++;
        if (!m_busy) begin
            n_fail++;
            $display("FAIL %s_grant: actual=no grant required=grant within %0d cycles", what, budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        aresetn = 1'b0;
        #1;
        chk("async_reset_m_axis_tvalid", m_tvalid, 1'b0);
        chk("async_reset_s_axis_tready", s_ready, '0);
        repeat (2) @(negedge clk);
        #3;
        aresetn = 1'b1;
    endtask

    task automatic set_all(input int vp, input int rp, input int lmin, input int lmax);
        for (int q = 0; q < NQ; q++) vprob[q] = vp;
        rprob   = rp;
        len_min = lmin;
        len_max = lmax;
    endtask

    initial begin
        for (int q = 0; q < NQ; q++) begin
            vprob[q]     = 100;
            gen_total[q] = 0;
            gen_made[q]  = 0;
        end
        repeat (3) @(negedge clk);
        #3;
        aresetn = 1'b1;

        // Single 3-beat packet from queue 2
        set_all(100, 100, 3, 3);
        act_base = act_seen;
        gen_total[2] += 1;
        drain(200, "q2_packet");
        chk("pkt_count_after_q2", pkt_count, 8'd1);
        chk("pulses_after_q2", act_seen - act_base, 1);

        // All queues continuously valid with single-beat packets
        set_all(100, 100, 1, 1);
        act_base = act_seen;
        for (int q = 0; q < NQ; q++) gen_total[q] += 2;
        drain(200, "rotate");
        chk("pkt_count_after_rotate", pkt_count, 8'd9);
        chk("pulses_after_rotate", act_seen - act_base, 8);

        // Queue 1 mid-packet with queue 0 waiting and a 10-cycle egress stall
        set_all(100, 100, 4, 4);
        gen_total[1] += 1;
        wait_busy(50, "q1_stall");
        gen_total[0] += 1;
        rprob = 0;
        repeat (10) @(negedge clk);
        rprob = 50;
        drain(500, "stall");

        // Randomised traffic, gaps and backpressure
        set_all(60, 60, 1, 6);
        for (int q = 0; q < NQ; q++) vprob[q] = 30 + int'($urandom_range(70));
        for (int q = 0; q < NQ; q++) gen_total[q] += 30;
        drain(20000, "random");

        // 256 single-beat packets from queue 3 wrap the counter
        do_reset();
        set_all(100, 100, 1, 1);
        act_base = act_seen;
        gen_total[3] += 256;
        drain(2000, "wrap");
        chk("pkt_count_wrap", pkt_count, 8'd0);
        chk("pulses_wrap", act_seen - act_base, 256);

        // Asynchronous reset mid-packet, then queue 0 must win first
        set_all(100, 100, 8, 8);
        gen_total[1] += 1;
        wait_busy(50, "pre_reset");
        repeat (2) @(negedge clk);
        do_reset();
        set_all(100, 100, 1, 1);
        for (int q = 0; q < NQ; q++) gen_total[q] += 1;
        wait_busy(50, "post_reset");
        chk("first_grant_after_reset", grant, 0);
        drain(200, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nf10_axis_pkt_rr_arbiter.md
Name: nf10_axis_pkt_rr_arbiter

Overview:
- Packet-level round-robin arbiter that shares one 256-bit AXI4-Stream egress port between NUM_QUEUES output-queue streams.
- Sits between the BRAM output queues and a 10G interface, DMA port or simulation record block.
- Never splits a packet: a grant is held from the first beat until the tlast beat is accepted.
- Exports a packet counter and an activity pulse for bench and debug observation.

Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width per stream; tstrb width is C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 128, tuser width per stream.
- NUM_QUEUES, 4, number of input streams; legal range 2..8.
- SEL_WIDTH, 2, grant index width; must satisfy 2**SEL_WIDTH >= NUM_QUEUES.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset, asynchronous assert, active-low.
- s_axis_tdata  in  NUM_QUEUES*C_AXIS_DATA_WIDTH  packed input data; queue i occupies slice i.
- s_axis_tstrb  in  NUM_QUEUES*C_AXIS_DATA_WIDTH/8  packed byte strobes.
- s_axis_tuser  in  NUM_QUEUES*C_AXIS_TUSER_WIDTH  packed sideband.
- s_axis_tvalid  in  NUM_QUEUES  per-queue valid.
- s_axis_tlast  in  NUM_QUEUES  per-queue last.
- s_axis_tready  out  NUM_QUEUES  per-queue ready.
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  egress data.
- m_axis_tstrb  out  C_AXIS_DATA_WIDTH/8  egress strobes.
- m_axis_tuser  out  C_AXIS_TUSER_WIDTH  egress sideband.
- m_axis_tvalid  out  1  egress valid.
- m_axis_tlast  out  1  egress last.
- m_axis_tready  in  1  egress ready.
- grant  out  SEL_WIDTH  index of the currently granted queue.
- pkt_count  out  8  packets forwarded, modulo 256.
- activity  out  1  one-cycle pulse per forwarded packet.

Behaviour:
- Reset (aresetn low, asynchronous):
  - state=IDLE; last_grant=NUM_QUEUES-1, so queue 0 has first priority.
  - grant=0, pkt_count=0, activity=0.
  - m_axis_tvalid=0 and all s_axis_tready=0 while in reset and IDLE.
- FSM states: IDLE and SEND.
- IDLE:
  - Search s_axis_tvalid starting at last_grant+1, wrapping modulo NUM_QUEUES.
  - First set bit found: register grant=index and go to SEND at the next edge.
  - No valid bit: stay in IDLE.
- SEND, datapath:
  - m_axis_tdata, tstrb, tuser and tlast are combinational mux outputs of slice[grant].
  - m_axis_tvalid = s_axis_tvalid[grant].
  - s_axis_tready[grant] = m_axis_tready; all other readies are 0.
  - No registers in the data path; latency is zero within SEND.
- SEND, transitions:
  - Handshake is m_axis_tvalid & m_axis_tready.
  - Handshake with m_axis_tlast=1: last_grant=grant, pkt_count+=1 (wraps 255->0), activity=1 for one cycle (registered), go to IDLE.
  - Otherwise stay in SEND.
  - If the granted queue drops tvalid mid-packet, the grant is held and m_axis_tvalid follows at 0. There is no timeout and no preemption.
- Packet spacing: one arbitration bubble cycle between packets, i.e. at least one cycle with m_axis_tvalid=0. Sustained rate for 1-beat packets is 1 packet per 2 cycles.
- Single-beat packet (tvalid & tlast on the first beat): one cycle in SEND, then IDLE.
- Backpressure: with m_axis_tready=0, outputs stay stable and no state changes.
- Fairness: with all queues continuously valid, grants rotate 0,1,2,...,NUM_QUEUES-1,0,...
- A queue that becomes valid while another queue is in SEND waits for the next IDLE.
- Reset asserted mid-packet: immediate return to the reset state; the partial packet is abandoned and the downstream block must tolerate it.
- grant is meaningful only in SEND; in IDLE it holds its last value.

Decomposition:
- Shared package (nf10_axis_pkg):
  - default widths 256/128/32;
  - FSM state encodings IDLE=1'b0, SEND=1'b1;
  - the function computing the packed-slice offset for index i.
- Sub-module nf10_rr_pick:
  - purely combinational rotate-priority encoder;
  - inputs: request vector, last_grant;
  - outputs: found, index.
  - Reusable by the input arbiter.
- FSM, counter and mux stay in the top module.

Test Plan:
- Reset then queue 2 sends a 3-beat packet with m_axis_tready=1 -> grant=2; beats appear on m_axis_* on 3 consecutive cycles, the last with tlast=1; pkt_count=1; activity pulses once.
- All 4 queues present 1-beat packets continuously for 16 cycles -> output order 0,1,2,3,0,1,2,3; 8 packets forwarded; tvalid alternates 1/0.
- Queue 1 mid-packet while queue 0 asserts tvalid, m_axis_tready toggling 1,0,1 -> no interleave; queue 0 is granted only after queue 1's tlast handshake; s_axis_tready[0]=0 throughout.
- Hold m_axis_tready=0 for 10 cycles during a 4-beat packet -> m_axis_tdata is unchanged across the stall; s_axis_tready[grant]=0; exactly 4 beats are delivered after release.
- Forward 256 single-beat packets from queue 3 -> pkt_count wraps to 0; activity produces 256 pulses.
- Assert aresetn=0 asynchronously mid-packet -> m_axis_tvalid and s_axis_tready go to 0 without waiting for aclk; after release, queue 0 wins the first arbitration.
